// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // One buffered instruction tagged with the PC it was fetched from
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Synchronous FIFO of fetch entries. Flush empties it in one
//               cycle and takes priority over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage write; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage. Issues one memory request at a time,
//               buffers tagged responses for decode, handles redirects by
//               flushing the buffer and dropping any in-flight response.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              drop;

  logic              push;
  logic              pop;
  fetch_entry_t      push_data;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  post_count;

  // Accept a response only when it belongs to the current fetch stream
  assign push       = (state == WAIT) && imem_rvalid && !drop && !redirect_valid;
  assign pop        = if_valid && if_ready;
  assign push_data  = '{pc: req_pc, instr: imem_rdata};
  assign post_count = count + CNT_W'(push) - CNT_W'(pop);

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Fetch FSM: a request is only issued when the FIFO can take its response
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
      imem_req <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_target);
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            // Old-address request is already accepted; its response must be dropped
            state    <= WAIT;
            imem_req <= 1'b0;
            drop     <= 1'b1;
          end else begin
            imem_req <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state    <= REQ;
            imem_req <= 1'b1;
            drop     <= 1'b0;
          end else begin
            drop <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count < DEPTH_CNT) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ready) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_INC;
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (post_count < DEPTH_CNT) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = fetch_pc;
  assign if_valid    = (count != '0);
  assign if_instr    = if_valid ? head.instr : '0;
  assign if_pc       = if_valid ? head.pc : '0;
  assign if_pc_plus4 = if_valid ? (head.pc + PC_INC) : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit. Two instances
//               share all inputs; the second uses RESET_PC = 0xFFFFFFFC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        if_ready = 1'b0;

  logic        req_a, valid_a, req_b, valid_b;
  logic [31:0] addr_a, instr_a, pc_a, pc4_a;
  logic [31:0] addr_b, instr_b, pc_b, pc4_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state (driven from the cycle task)
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          lat = 0;
  bit          override = 1'b0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .reset(reset),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(valid_a), .if_ready(if_ready), .if_instr(instr_a),
    .if_pc(pc_a), .if_pc_plus4(pc4_a)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(valid_b), .if_ready(if_ready), .if_instr(instr_b),
    .if_pc(pc_b), .if_pc_plus4(pc4_b)
  );

  function automatic logic [31:0] data_for(input logic [31:0] a);
    if (override)      return 32'hDEAD_BEEF;
    else if (a == '0)  return 32'h2008_0005;
    else               return 32'h1300_0000 | a;
  endfunction

  // One clock: drive memory response, advance, update the memory model
  task automatic cycle();
    bit          accepted;
    logic [31:0] acc_addr;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend && pend_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_for(pend_addr);
    end
    accepted = req_a && imem_ready;
    acc_addr = addr_a;
    @(posedge clk); #1;
    if (imem_rvalid) pend = 1'b0;
    else if (pend)   pend_cnt--;
    if (accepted) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = acc_addr;
    end
    imem_rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    pend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    imem_ready = 1'b1;
    if_ready   = 1'b1;
    lat        = 0;
    apply_reset();
    n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %h want 0", req_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %h want 0", valid_a); end
    n_cmp++; if (addr_a !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 00000000", addr_a); end
    n_cmp++; if (pc_a !== 32'h0 || pc4_a !== 32'h0 || instr_a !== 32'h0) begin
      n_bad++; $display("FAIL rst_head: got %h/%h/%h want 0/0/0", pc_a, pc4_a, instr_a); end
    n_cmp++; if (addr_b !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL rst_addr_b: got %h want fffffffc", addr_b); end
    reset = 1'b0;
    cycle();
    n_cmp++; if (req_a !== 1'b1) begin n_bad++; $display("FAIL first_req: got %h want 1", req_a); end
    n_cmp++; if (addr_a !== 32'h0) begin n_bad++; $display("FAIL first_addr: got %h want 00000000", addr_a); end
  endtask

  task automatic test_zero_wait();
    cycle();  // request 0 accepted
    n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL zw_wait_req: got %h want 0", req_a); end
    cycle();  // response for 0
    n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL zw_valid: got %h want 1", valid_a); end
    n_cmp++; if (instr_a !== 32'h2008_0005) begin n_bad++; $display("FAIL zw_instr: got %h want 20080005", instr_a); end
    n_cmp++; if (pc_a !== 32'h0) begin n_bad++; $display("FAIL zw_pc: got %h want 00000000", pc_a); end
    n_cmp++; if (pc4_a !== 32'h4) begin n_bad++; $display("FAIL zw_pc4: got %h want 00000004", pc4_a); end
    n_cmp++; if (req_a !== 1'b1 || addr_a !== 32'h4) begin
      n_bad++; $display("FAIL zw_next_req: got %h/%h want 1/00000004", req_a, addr_a); end
    n_cmp++; if (pc_b !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc: got %h want fffffffc", pc_b); end
    n_cmp++; if (pc4_b !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h want 00000000", pc4_b); end
    n_cmp++; if (addr_b !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 00000000", addr_b); end
    cycle();  // head popped, request 4 accepted
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL zw_gap: got %h want 0", valid_a); end
    cycle();  // response for 4
    n_cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h4 || instr_a !== 32'h1300_0004 || pc4_a !== 32'h8) begin
      n_bad++; $display("FAIL zw_second: got %h/%h/%h/%h want 1/00000004/13000004/00000008",
                        valid_a, pc_a, instr_a, pc4_a); end
  endtask

  task automatic test_backpressure();
    if_ready = 1'b0;
    apply_reset();
    reset = 1'b0;
    repeat (5) cycle();
    repeat (3) cycle();
    n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL bp_req: got %h want 0", req_a); end
    n_cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h0) begin
      n_bad++; $display("FAIL bp_head: got %h/%h want 1/00000000", valid_a, pc_a); end
    if_ready = 1'b1;
    cycle();
    n_cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h4 || req_a !== 1'b0) begin
      n_bad++; $display("FAIL bp_pop1: got %h/%h/%h want 1/00000004/0", valid_a, pc_a, req_a); end
    cycle();
    n_cmp++; if (valid_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 32'h8) begin
      n_bad++; $display("FAIL bp_pop2: got %h/%h/%h want 0/1/00000008", valid_a, req_a, addr_a); end
  endtask

  task automatic test_redirect_wait();
    lat = 2;
    cycle();  // request 8 accepted, now waiting
    redirect_valid  = 1'b1;
    redirect_target = 32'h0040_0022;
    override        = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    n_cmp++; if (req_a !== 1'b0 || valid_a !== 1'b0) begin
      n_bad++; $display("FAIL rw_hold: got %h/%h want 0/0", req_a, valid_a); end
    cycle();
    cycle();  // stale response arrives and is dropped
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL rw_drop: got %h want 0", valid_a); end
    n_cmp++; if (req_a !== 1'b1 || addr_a !== 32'h0040_0020) begin
      n_bad++; $display("FAIL rw_next: got %h/%h want 1/00400020", req_a, addr_a); end
    override = 1'b0;
    lat      = 0;
  endtask

  task automatic test_redirect_accept();
    imem_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0010;
    cycle();
    redirect_valid = 1'b0;
    n_cmp++; if (req_a !== 1'b1 || addr_a !== 32'h10) begin
      n_bad++; $display("FAIL ra_retract: got %h/%h want 1/00000010", req_a, addr_a); end
    imem_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    cycle();  // 0x10 accepted alongside the redirect
    redirect_valid = 1'b0;
    n_cmp++; if (req_a !== 1'b0 || valid_a !== 1'b0) begin
      n_bad++; $display("FAIL ra_wait: got %h/%h want 0/0", req_a, valid_a); end
    cycle();  // 0x10 response discarded
    n_cmp++; if (valid_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 32'h100) begin
      n_bad++; $display("FAIL ra_next: got %h/%h/%h want 0/1/00000100", valid_a, req_a, addr_a); end
    cycle();
    cycle();
    n_cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h100 || instr_a !== 32'h1300_0100 || pc4_a !== 32'h104) begin
      n_bad++; $display("FAIL ra_entry: got %h/%h/%h/%h want 1/00000100/13000100/00000104",
                        valid_a, pc_a, instr_a, pc4_a); end
  endtask

  task automatic test_flush_and_late_redirect();
    imem_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    cycle();  // buffered entry flushed, same-cycle pop ignored
    redirect_valid = 1'b0;
    n_cmp++; if (valid_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 32'h200) begin
      n_bad++; $display("FAIL fl_flush: got %h/%h/%h want 0/1/00000200", valid_a, req_a, addr_a); end
    imem_ready = 1'b1;
    cycle();  // 0x200 accepted
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    cycle();  // response arrives together with redirect
    redirect_valid = 1'b0;
    n_cmp++; if (valid_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 32'h300) begin
      n_bad++; $display("FAIL fl_late: got %h/%h/%h want 0/1/00000300", valid_a, req_a, addr_a); end
    cycle();
    cycle();
    n_cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h300 || instr_a !== 32'h1300_0300) begin
      n_bad++; $display("FAIL fl_nodrop: got %h/%h/%h want 1/00000300/13000300", valid_a, pc_a, instr_a); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept();
    test_flush_and_late_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
